// File: rtl/conv2d_transpose_stream.sv
// conv2d_transpose_stream: streaming 2x2/stride-2 transposed convolution (decoder upsampler).
//   Accepts one input pixel (IN_CH channel beats) at a time and emits 4*OUT_CH tagged results
//   per pixel, ordered kc fastest, then kr, then oc. There are no frame buffers.
// Ports:
//   clk, rst                         rising-edge clock, synchronous active-high reset
//   start, relu_en                   frame start pulse (honoured in IDLE); ReLU select latched on start
//   in_data/in_valid/in_ready        input sample stream, channel-fastest, then col, then row
//   w_we/w_addr/w_data               weight write, addr = ((oc*2+kr)*2+kc)*IN_CH+ic (ignored while busy)
//   b_we/b_addr/b_data               bias write per output channel (ignored while busy)
//   out_data/out_row/out_col/out_ch  result and its output-map tag
//   out_valid/out_ready              output handshake; out_* hold until accepted
//   busy, done, sat_flag             frame active, end-of-frame pulse, sticky saturation flag
module conv2d_transpose_stream #(
   parameter int IN_H = 16,
   parameter int IN_W = 16,
   parameter int IN_CH = 8,
   parameter int OUT_CH = 4,
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_WIDTH = 8,
   localparam int DW = DATA_WIDTH,
   localparam int WAW = $clog2(OUT_CH * 4 * IN_CH),
   localparam int OCW = OUT_CH > 1 ? $clog2(OUT_CH) : 1,
   localparam int RW = $clog2(2 * IN_H),
   localparam int CW = $clog2(2 * IN_W)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           relu_en,
   input  logic [DW-1:0]  in_data,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           w_we,
   input  logic [WAW-1:0] w_addr,
   input  logic [DW-1:0]  w_data,
   input  logic           b_we,
   input  logic [OCW-1:0] b_addr,
   input  logic [DW-1:0]  b_data,
   output logic [DW-1:0]  out_data,
   output logic [RW-1:0]  out_row,
   output logic [CW-1:0]  out_col,
   output logic [OCW-1:0] out_ch,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           busy,
   output logic           done,
   output logic           sat_flag
);
   localparam int ICW = IN_CH > 1 ? $clog2(IN_CH) : 1;
   localparam int AW = 2 * DW + $clog2(IN_CH) + 1;
   localparam logic signed [AW:0] MAX_V = (AW+1)'((1 << (DW - 1)) - 1);
   localparam logic signed [AW:0] MIN_V = ~MAX_V;

   typedef enum logic [2:0] {IDLE, LOAD, MAC, EMIT, DONE} state_t;

   state_t state, state_n;
   logic [ICW-1:0] ic;
   logic kr, kc;
   logic [OCW-1:0] oc;
   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic relu_q;
   logic signed [DW-1:0] pix [IN_CH];
   logic signed [DW-1:0] w_mem [OUT_CH*4*IN_CH];
   logic signed [DW-1:0] b_mem [OUT_CH];
   logic signed [AW-1:0] acc, acc_base, acc_n;
   logic signed [2*DW-1:0] prod;
   logic signed [AW:0] res;
   logic signed [DW-1:0] sat_v, res_v;
   logic [WAW-1:0] w_idx;
   logic last_ic, last_k, last_px, clip_hi, clip_lo;

   assign last_ic = ic == ICW'(IN_CH - 1);
   assign last_k = kc && kr && oc == OCW'(OUT_CH - 1);
   assign last_px = row == RW'(IN_H - 1) && col == CW'(IN_W - 1);
   assign w_idx = WAW'(((int'(oc) * 2 + int'(kr)) * 2 + int'(kc)) * IN_CH + int'(ic));
   assign prod = pix[ic] * w_mem[w_idx];
   assign acc_base = ic == '0 ? '0 : acc;
   assign acc_n = acc_base + AW'(prod);
   // Arithmetic shift truncates toward -inf; bias is aligned to the same Q format.
   assign res = (AW+1)'(acc_n >>> FRAC_WIDTH) + (AW+1)'(b_mem[oc]);
   assign clip_hi = res > MAX_V;
   assign clip_lo = res < MIN_V;
   assign sat_v = clip_hi ? MAX_V[DW-1:0] : clip_lo ? MIN_V[DW-1:0] : res[DW-1:0];
   assign res_v = relu_q && sat_v[DW-1] ? '0 : sat_v;
   assign out_row = (row << 1) | RW'(kr);
   assign out_col = (col << 1) | CW'(kc);
   assign out_ch = oc;

   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;

   always_comb begin
      state_n = state;
      in_ready = 1'b0;
      out_valid = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         IDLE: state_n = start ? LOAD : IDLE;
         LOAD: begin
            in_ready = 1'b1;
            busy = 1'b1;
            state_n = in_valid && last_ic ? MAC : LOAD;
         end
         MAC: begin
            busy = 1'b1;
            state_n = last_ic ? EMIT : MAC;
         end
         EMIT: begin
            out_valid = 1'b1;
            busy = 1'b1;
            state_n = !out_ready ? EMIT : !last_k ? MAC : last_px ? DONE : LOAD;
         end
         DONE: begin
            done = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ic <= '0;
         kr <= 1'b0;
         kc <= 1'b0;
         oc <= '0;
         row <= '0;
         col <= '0;
         relu_q <= 1'b0;
         sat_flag <= 1'b0;
         out_data <= '0;
         acc <= '0;
      end else begin
         if (state == IDLE && start) begin
            ic <= '0;
            kr <= 1'b0;
            kc <= 1'b0;
            oc <= '0;
            row <= '0;
            col <= '0;
            relu_q <= relu_en;
            sat_flag <= 1'b0;
         end
         if (state == LOAD && in_valid)
            ic <= last_ic ? '0 : ic + 1'b1;
         if (state == MAC) begin
            acc <= acc_n;
            ic <= last_ic ? '0 : ic + 1'b1;
            if (last_ic) begin
               out_data <= res_v;
               sat_flag <= sat_flag | clip_hi | clip_lo;
            end
         end
         // Tag counters advance only on the handshake so out_* stay stable under backpressure.
         if (state == EMIT && out_ready) begin
            kc <= !kc;
            kr <= kr ^ kc;
            if (kc && kr)
               oc <= last_k ? '0 : oc + 1'b1;
            if (last_k) begin
               col <= col == CW'(IN_W - 1) ? '0 : col + 1'b1;
               if (col == CW'(IN_W - 1))
                  row <= last_px ? '0 : row + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == LOAD && in_valid)
         pix[ic] <= in_data;
      if (w_we && !busy)
         w_mem[w_addr] <= w_data;
      if (b_we && !busy)
         b_mem[b_addr] <= b_data;
   end
endmodule

// File: tb/tb_conv2d_transpose_stream.sv
// tb_conv2d_transpose_stream: directed checks of the 2x2/stride-2 transposed convolution.
module tb_conv2d_transpose_stream;
   localparam int IC = 2;

   logic clk = 1'b0;
   logic rst, start, relu_en, in_valid, in_ready, w_we, b_we;
   logic out_valid, out_ready, busy, done, sat_flag;
   logic [15:0] in_data, w_data, b_data, out_data;
   logic [3:0] w_addr;
   logic [0:0] b_addr, out_ch;
   logic [1:0] out_row, out_col;

   conv2d_transpose_stream #(
      .IN_H(2), .IN_W(2), .IN_CH(2), .OUT_CH(2), .DATA_WIDTH(16), .FRAC_WIDTH(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
      .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_ch(out_ch),
      .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] din;
      logic [15:0] w;
      logic [15:0] b;
      logic        relu;
      logic [15:0] exp;
      logic        exp_sat;
   } vec_t;

   vec_t tv[10];
   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] pix_tb[8];
   logic [15:0] g_data[32];
   logic [1:0] g_row[32], g_col[32];
   logic g_ch[32];
   int n_out;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wr(input bit is_b, input int a, input logic [15:0] v);
      @(negedge clk);
      if (is_b) begin
         b_we = 1'b1;
         b_addr = a[0:0];
         b_data = v;
      end else begin
         w_we = 1'b1;
         w_addr = a[3:0];
         w_data = v;
      end
      @(negedge clk);
      w_we = 1'b0;
      b_we = 1'b0;
   endtask

   task automatic load_uniform(input logic [15:0] w, input logic [15:0] b);
      for (int i = 0; i < 16; i++) wr(1'b0, i, w);
      for (int i = 0; i < 2; i++) wr(1'b1, i, b);
   endtask

   // addr = ((oc*2+kr)*2+kc)*2+ic, so oc = addr[3] and ic = addr[0]
   task automatic load_identity();
      for (int i = 0; i < 16; i++) wr(1'b0, i, ((i >> 3) == (i & 1)) ? 16'h0100 : 16'h0000);
      for (int i = 0; i < 2; i++) wr(1'b1, i, 16'h0000);
   endtask

   // Runs one frame. bp_at: output index that gets 10 cycles of out_ready low;
   // abort_at: pulse rst in the MAC phase of that output; spur_at: cycle of a start+weight write while busy.
   task automatic run_frame(input logic relu, input int bp_at, input int abort_at, input int spur_at);
      int beat = 0, cyc = 0, hold = 0, t_evt = 0;
      bit fin = 0, bp_done = 0, prev_ov = 0;
      logic [20:0] snap = '0;
      n_out = 0;
      for (int k = 0; k < 32; k++) begin
         g_data[k] = 'x;
         g_row[k] = 'x;
         g_col[k] = 'x;
         g_ch[k] = 'x;
      end
      @(negedge clk);
      start = 1'b1;
      relu_en = relu;
      @(negedge clk);
      start = 1'b0;
      relu_en = 1'b0;
      while (!fin && cyc < 2000) begin
         start = (cyc == spur_at);
         relu_en = (cyc == spur_at);
         w_we = (cyc == spur_at);
         w_addr = 4'd0;
         w_data = 16'h0000;
         if (done) fin = 1;
         else if (abort_at >= 0 && n_out == abort_at && !out_valid) begin
            in_valid = 1'b0;
            out_ready = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            fin = 1;
         end else begin
            in_valid = beat < 8;
            in_data = beat < 8 ? pix_tb[beat] : 16'h0000;
            if (!bp_done && bp_at >= 0 && n_out == bp_at && out_valid) begin
               bp_done = 1;
               hold = 10;
               snap = {out_data, out_row, out_col, out_ch};
            end
            out_ready = hold == 0;
            if (hold > 0) begin
               chk("bp_hold", {out_valid, in_ready, out_data, out_row, out_col, out_ch}, {1'b1, 1'b0, snap});
               hold--;
            end
            if (out_valid && !prev_ov) chk("latency", cyc - t_evt, IC + 1);
            prev_ov = out_valid;
            if (in_valid && in_ready) begin
               beat++;
               if (beat % 2 == 0) t_evt = cyc;
            end
            if (out_valid && out_ready) begin
               if (n_out < 32) begin
                  g_data[n_out] = out_data;
                  g_row[n_out] = out_row;
                  g_col[n_out] = out_col;
                  g_ch[n_out] = out_ch[0];
               end
               n_out++;
               t_evt = cyc;
            end
         end
         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end
      w_we = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      if (!fin) begin
         n_cmp++;
         n_err++;
         $display("FAIL frame_timeout: got %0d outputs, required done within 2000 cycles", n_out);
      end
   endtask

   task automatic chk_identity(input string tag);
      logic [15:0] ed;
      logic [1:0] er, ec;
      logic eh;
      chk({tag, "_count"}, n_out, 32);
      for (int k = 0; k < 32; k++) begin
         int p = k / 8, oc = (k / 4) % 2, kr = (k / 2) % 2, kc = k % 2;
         ed = 16'(p * 2 + oc + 1);
         er = 2'(2 * (p / 2) + kr);
         ec = 2'(2 * (p % 2) + kc);
         eh = oc[0];
         chk($sformatf("%s_out%0d", tag, k), {g_data[k], g_row[k], g_col[k], g_ch[k]}, {ed, er, ec, eh});
      end
   endtask

   task automatic chk_post_done(input string tag);
      @(negedge clk);
      chk({tag, "_post_done"}, {done, busy}, 2'b00);
   endtask

   task automatic chk_reset_state(input string tag);
      chk(tag, {in_ready, out_valid, busy, done, sat_flag, out_data, out_row, out_col, out_ch}, 0);
   endtask

   initial begin
      tv[0] = '{16'h0100, 16'h0080, 16'h0040, 1'b0, 16'h0140, 1'b0};
      tv[1] = '{16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 16'h7FFF, 1'b1};
      tv[2] = '{16'h8000, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 1'b1};
      tv[3] = '{16'h0100, 16'h0080, 16'h0040, 1'b0, 16'h0140, 1'b0};
      tv[4] = '{16'hFF00, 16'h0100, 16'h0000, 1'b1, 16'h0000, 1'b0};
      tv[5] = '{16'hFF00, 16'h0100, 16'h0000, 1'b0, 16'hFE00, 1'b0};
      tv[6] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
      tv[7] = '{16'h4000, 16'h0100, 16'h0000, 1'b0, 16'h7FFF, 1'b1};
      tv[8] = '{16'h3FFF, 16'h0100, 16'h0001, 1'b0, 16'h7FFF, 1'b0};
      tv[9] = '{16'h0000, 16'h0000, 16'hFF00, 1'b0, 16'hFF00, 1'b0};
      rst = 1'b1;
      start = 1'b0;
      relu_en = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      w_we = 1'b0;
      w_addr = '0;
      w_data = '0;
      b_we = 1'b0;
      b_addr = '0;
      b_data = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_reset_state("reset_state");

      for (int i = 0; i < 10; i++) begin
         load_uniform(tv[i].w, tv[i].b);
         for (int j = 0; j < 8; j++) pix_tb[j] = tv[i].din;
         run_frame(tv[i].relu, -1, -1, -1);
         chk($sformatf("vec%0d_count", i), n_out, 32);
         chk($sformatf("vec%0d_sat", i), sat_flag, tv[i].exp_sat);
         for (int k = 0; k < 32; k++) chk($sformatf("vec%0d_out%0d", i, k), g_data[k], tv[i].exp);
         chk_post_done($sformatf("vec%0d", i));
      end

      load_uniform(16'h7FFF, 16'h0000);
      for (int j = 0; j < 8; j++) pix_tb[j] = 16'h7FFF;
      run_frame(1'b0, -1, 5, -1);
      chk_reset_state("rst_mid_mac_sat");

      load_identity();
      for (int j = 0; j < 8; j++) pix_tb[j] = 16'(j + 1);
      run_frame(1'b0, -1, -1, -1);
      chk_identity("identity");
      chk_post_done("identity");

      run_frame(1'b0, 3, -1, -1);
      chk_identity("backpressure");
      chk_post_done("backpressure");

      run_frame(1'b0, -1, 13, -1);
      chk_reset_state("rst_mid_mac_id");

      run_frame(1'b0, -1, -1, 10);
      chk_identity("rerun");
      chk_post_done("rerun");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
